// File: rtl/axi_sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between an AXI slave's read and write beat ports.
// Whole bursts are granted per direction, with round-robin and a beat cap when the other side waits.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no grant; picks the requester (opposite last_dir on a tie)
// READ    | read port owns the SRAM; RD_READY high
// WRITE   | write port owns the SRAM; WR_READY high
// TURN    | one bubble cycle between directions, then opposite last_dir
module axi_sram_port_arbiter #(
    parameter int width      = 22,
    parameter int p_size     = 3,
    parameter int rd_latency = 1,
    parameter int max_burst  = 16,
    parameter int turnaround = 1
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        RD_VALID,
    input  logic [width-1:0]            RD_ADDR,
    input  logic                        RD_LAST,
    output logic                        RD_READY,
    output logic [(8<<p_size)-1:0]      RD_DATA,
    output logic                        RD_DATA_VALID,
    input  logic                        WR_VALID,
    input  logic [width-1:0]            WR_ADDR,
    input  logic [(8<<p_size)-1:0]      WR_DATA,
    input  logic [(1<<p_size)-1:0]      WR_BE,
    input  logic                        WR_LAST,
    output logic                        WR_READY,
    output logic                        SRAM_CE,
    output logic                        SRAM_WE,
    output logic [width-1:0]            SRAM_ADDR,
    output logic [(8<<p_size)-1:0]      SRAM_WDATA,
    output logic [(1<<p_size)-1:0]      SRAM_BE,
    input  logic [(8<<p_size)-1:0]      SRAM_RDATA
);

    localparam int cnt_w = $clog2(max_burst) + 1;
    localparam logic [cnt_w-1:0] cap_val = cnt_w'(max_burst - 1);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_read  = 2'd1,
        st_write = 2'd2,
        st_turn  = 2'd3
    } state_t;

    state_t              state;
    logic                last_dir;      // 1 = write
    logic [cnt_w-1:0]    beat_cnt;
    logic                mid_burst;
    logic [rd_latency-1:0] rd_pipe;

    logic   cur_write;
    logic   rd_acc;
    logic   wr_acc;
    logic   acc;
    logic   last_beat;
    logic   own_valid;
    logic   other_valid;
    logic   at_cap;
    logic   burst_end;
    state_t other_grant;
    state_t handover;

    always_comb begin
        cur_write   = (state == st_write);
        rd_acc      = (state == st_read) && RD_VALID;
        wr_acc      = (state == st_write) && WR_VALID;
        acc         = rd_acc || wr_acc;
        last_beat   = cur_write ? WR_LAST : RD_LAST;
        own_valid   = cur_write ? WR_VALID : RD_VALID;
        other_valid = cur_write ? RD_VALID : WR_VALID;
        at_cap      = (beat_cnt == cap_val);
        burst_end   = acc && (last_beat || (at_cap && other_valid));
        other_grant = cur_write ? st_read : st_write;
        handover    = (turnaround != 0) ? st_turn : other_grant;
    end

    assign RD_READY = (state == st_read);
    assign WR_READY = (state == st_write);

    always_comb begin
        SRAM_CE    = 1'b0;
        SRAM_WE    = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WDATA = '0;
        SRAM_BE    = '0;
        if (rd_acc) begin
            SRAM_CE   = 1'b1;
            SRAM_ADDR = RD_ADDR;
            SRAM_BE   = '1;
        end else if (wr_acc) begin
            SRAM_CE    = 1'b1;
            SRAM_WE    = 1'b1;
            SRAM_ADDR  = WR_ADDR;
            SRAM_WDATA = WR_DATA;
            SRAM_BE    = WR_BE;
        end
    end

    // Between bursts (mid_burst low) a grant with no own request is released,
    // so a finished burst falls back to IDLE or hands over to a waiting side.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= st_idle;
            last_dir  <= 1'b1;
            beat_cnt  <= '0;
            mid_burst <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (RD_VALID && (!WR_VALID || last_dir))
                        state <= st_read;
                    else if (WR_VALID)
                        state <= st_write;
                end
                st_read, st_write: begin
                    if (burst_end) begin
                        last_dir  <= cur_write;
                        beat_cnt  <= '0;
                        mid_burst <= 1'b0;
                        if (other_valid)
                            state <= handover;
                    end else if (acc) begin
                        beat_cnt  <= at_cap ? '0 : beat_cnt + 1'b1;
                        mid_burst <= 1'b1;
                    end else if (!mid_burst && !own_valid) begin
                        last_dir <= cur_write;
                        state    <= other_valid ? handover : st_idle;
                    end
                end
                st_turn: begin
                    state <= last_dir ? st_read : st_write;
                end
                default: state <= st_idle;
            endcase
        end
    end

    generate
        if (rd_latency == 1) begin : g_pipe1
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) rd_pipe <= '0;
                else        rd_pipe <= rd_acc;
            end
        end else begin : g_pipen
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) rd_pipe <= '0;
                else        rd_pipe <= {rd_pipe[rd_latency-2:0], rd_acc};
            end
        end
    endgenerate

    assign RD_DATA_VALID = rd_pipe[rd_latency-1];
    assign RD_DATA       = RD_DATA_VALID ? SRAM_RDATA : '0;

endmodule
